// File: rtl/rotation_feeder.sv
// rotation_feeder: frame sequencer in front of the CORDIC `rotation` pipeline.
// Once per frame it optionally advances the spin angle, streams the vertex table
// (one point per cycle) into the pipeline, and captures the rotated results,
// tagged with their vertex index, at the far end of a latency-matched tag pipe.
// Points in the left half-plane of the angle circle are pre-rotated by 180 deg
// so the pipeline only ever sees angles in -90..90 deg.
//
// Ports:
//   clk, reset          clock; asynchronous active-low reset
//   frame_start         one-cycle frame pulse
//   spin_en, dir        advance angle by +/-STEP on an accepted frame
//   pt_we/pt_waddr/pt_wx/pt_wy   vertex table write port
//   angle, x, y         registered point to `rotation`
//   x_rot, y_rot        result from `rotation`
//   out_valid/out_index/out_x/out_y   captured rotated point
//   busy, done, overrun frame status
module rotation_feeder #(
  parameter int          NPTS    = 16,
  parameter int          LATENCY = 12,
  parameter logic [31:0] STEP    = 32'd11930465,
  localparam int         IW      = $clog2(NPTS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          frame_start,
  input  logic          spin_en,
  input  logic          dir,
  input  logic          pt_we,
  input  logic [IW-1:0] pt_waddr,
  input  logic [11:0]   pt_wx,
  input  logic [11:0]   pt_wy,
  output logic [31:0]   angle,
  output logic [11:0]   x,
  output logic [11:0]   y,
  input  logic [11:0]   x_rot,
  input  logic [10:0]   y_rot,
  output logic          out_valid,
  output logic [IW-1:0] out_index,
  output logic [11:0]   out_x,
  output logic [10:0]   out_y,
  output logic          busy,
  output logic          done,
  output logic          overrun
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_e;

  state_e        state_q;
  logic [31:0]   theta_q, theta_d;
  logic [IW-1:0] idx_q;
  logic [31:0]   angle_q, ang_d;
  logic [11:0]   x_q, y_q, x_d, y_d;
  logic          out_valid_q, done_q, overrun_q;
  logic [IW-1:0] out_index_q;
  logic [11:0]   out_x_q;
  logic [10:0]   out_y_q;

  // Tag pipe: entry 0 is loaded together with the issue register, entry
  // LATENCY lines up with the matching x_rot/y_rot.
  logic [LATENCY:0]         vld_pipe;
  logic [LATENCY:0][IW-1:0] idx_pipe;

  // Vertex table, not reset. Combinational read, so a same-cycle write
  // is seen only on the following cycle.
  logic [23:0] mem_q [NPTS];
  logic [11:0] px, py;
  logic        flip;

  always_ff @(posedge clk) begin
    if (pt_we) mem_q[pt_waddr] <= {pt_wx, pt_wy};
  end

  function automatic logic [11:0] neg_sat(input logic [11:0] v);
    return (v == 12'h800) ? 12'h7FF : (~v + 12'd1);
  endfunction

  always_comb begin
    theta_d = theta_q;
    if (state_q == IDLE && frame_start && spin_en)
      theta_d = dir ? (theta_q - STEP) : (theta_q + STEP);
    {px, py} = mem_q[idx_q];
    // Quadrants 01/10 lie outside -90..90 deg: add 180 deg and negate point.
    flip  = theta_q[31] ^ theta_q[30];
    ang_d = flip ? (theta_q + 32'h8000_0000) : theta_q;
    x_d   = flip ? neg_sat(px) : px;
    y_d   = flip ? neg_sat(py) : py;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      theta_q     <= '0;
      idx_q       <= '0;
      angle_q     <= '0;
      x_q         <= '0;
      y_q         <= '0;
      vld_pipe    <= '0;
      idx_pipe    <= '0;
      out_valid_q <= 1'b0;
      out_index_q <= '0;
      out_x_q     <= '0;
      out_y_q     <= '0;
      done_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      theta_q   <= theta_d;
      vld_pipe  <= {vld_pipe[LATENCY-1:0], (state_q == ISSUE)};
      idx_pipe  <= {idx_pipe[LATENCY-1:0], idx_q};
      overrun_q <= frame_start && (state_q != IDLE);

      out_valid_q <= vld_pipe[LATENCY];
      done_q      <= vld_pipe[LATENCY] && (idx_pipe[LATENCY] == IW'(NPTS - 1));
      if (vld_pipe[LATENCY]) begin
        out_x_q     <= x_rot;
        out_y_q     <= y_rot;
        out_index_q <= idx_pipe[LATENCY];
      end

      case (state_q)
        IDLE: begin
          if (frame_start) begin
            state_q <= ISSUE;
            idx_q   <= '0;
          end
        end
        ISSUE: begin
          angle_q <= ang_d;
          x_q     <= x_d;
          y_q     <= y_d;
          idx_q   <= idx_q + 1'b1;
          if (idx_q == IW'(NPTS - 1)) state_q <= DRAIN;
        end
        DRAIN: begin
          // Leave one cycle after the last capture so busy covers done.
          if (done_q) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign angle     = angle_q;
  assign x         = x_q;
  assign y         = y_q;
  assign out_valid = out_valid_q;
  assign out_index = out_index_q;
  assign out_x     = out_x_q;
  assign out_y     = out_y_q;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign overrun   = overrun_q;

endmodule

// File: doc/rotation_feeder.md
# rotation_feeder

Frame-level sequencer that sits directly upstream of the CORDIC `rotation` pipeline and also captures its results. Once per frame it advances a spin angle, streams a small vertex table through the pipeline one point per cycle, and extends the pipeline's usable range to a full 360° with quadrant pre-rotation. A tag shift register matched to the pipeline latency returns each rotated point with its vertex index.

## Interface
Parameters:
- `NPTS`, 16: vertices per frame; power of two, ≤ 64.
- `LATENCY`, 12: cycles from `rotation` input sample edge to valid `x_rot`/`y_rot`.
- `STEP`, 32'd11930465: angle increment per frame, about 1°; the 32-bit angle maps 2^32 to 360°.

Ports:
- `clk`  in  1  system clock; one clock domain.
- `reset`  in  1  asynchronous, active-low reset.
- `frame_start`  in  1  one-cycle frame pulse (vsync-derived).
- `spin_en`  in  1  advance the angle on an accepted frame.
- `dir`  in  1  0 adds `STEP`, 1 subtracts `STEP`.
- `pt_we`  in  1  vertex table write enable.
- `pt_waddr`  in  log2(NPTS)  vertex table write address.
- `pt_wx`, `pt_wy`  in  12 each  signed vertex coordinates.
- `angle`  out  32  signed angle to `rotation`, registered.
- `x`, `y`  out  12 each  signed point to `rotation`, registered.
- `x_rot`  in  12  signed result from `rotation`.
- `y_rot`  in  11  signed result from `rotation`.
- `out_valid`  out  1  rotated point present on the outputs.
- `out_index`  out  log2(NPTS)  vertex index of the current output point.
- `out_x`  out  12  signed rotated x, registered.
- `out_y`  out  11  signed rotated y, registered.
- `busy`  out  1  frame in progress.
- `done`  out  1  one-cycle pulse with the last output point.
- `overrun`  out  1  one-cycle pulse when a `frame_start` arrives while busy.

## Operation
- Reset values: all outputs 0; `theta` = 0; FSM = IDLE; tag pipe cleared. The vertex table is not reset.
- Vertex table: NPTS×24-bit register file.
  - Writes are accepted in every state.
  - A read of an address written in the same cycle returns the old data.
- FSM states: IDLE, ISSUE, DRAIN.
  - IDLE→ISSUE on `frame_start`.
    - If `spin_en`, `theta` ← `theta` ± `STEP`, wrapping mod 2^32.
    - `idx` ← 0.
  - ISSUE:
    - Each cycle, read vertex `idx`, pre-rotate it, register it onto `angle`/`x`/`y`, push tag {1,`idx`}, then increment `idx`.
    - After `idx` = NPTS−1, go to DRAIN.
  - DRAIN:
    - Push tag {0,–} each cycle.
    - When the last valid tag emerges, go to IDLE.
- Quadrant pre-rotation uses `theta[31:30]`:
  - 00 or 11 (−90°..90°): pass `theta`, x, y unchanged.
  - 01 or 10: `angle` = `theta` + 2^31; `x` = −px; `y` = −py.
  - Negating −2048 saturates to +2047.
- Capture:
  - The tag pipe is LATENCY+1 deep, measured from the issue register.
  - When a valid tag reaches the end, register `x_rot`/`y_rot` into `out_x`/`out_y`, set `out_valid` = 1 and `out_index` = tag index.
  - Otherwise `out_valid` = 0 and `out_x`/`out_y` hold their values.
- `frame_start` while `busy` is ignored: no angle update, `overrun` pulses.
- `frame_start` in the same cycle that `done` pulses is also ignored.
- Between frames, `angle`/`x`/`y` hold their last values.

## Timing
- Cycle 0 is the edge that samples `frame_start`=1 in IDLE.
  - Vertex k is on `angle`/`x`/`y` from edge 1+k.
  - Its result appears on `out_*` from edge k+LATENCY+2.
- `busy` is high from edge 1 through edge NPTS+LATENCY+1.
- `done` pulses with the final `out_valid`, at edge NPTS+LATENCY+1.
- Throughput: one point per cycle; frame cost NPTS+LATENCY+2 cycles.
- `reset` asserted mid-frame:
  - All outputs drop to 0 immediately; the tag pipe and FSM clear.
  - Results still inside `rotation` are discarded, because no valid tags remain.

## Test plan
- Reset: hold `reset`=0 with random inputs → all outputs 0, `busy`=0; after release, `theta`=0.
- Identity: load vertex 0 = (1000,0), `spin_en`=0, pulse `frame_start` → vertex 0 on `out_*` at edge LATENCY+2, `out_x` = 1000±4, `out_y` = 0±4, `out_index`=0; `done` at edge NPTS+LATENCY+1.
- Quadrant: 90 frames with `spin_en`=1, `dir`=0 → `theta[31:30]`=01; vertex (500,0) → `out_x` = 0±6, `out_y` = 500±6; `x` driven as −500.
- Wrap: from reset, one frame with `dir`=1 → `theta` = 2^32−11930465; vertex (500,0) → `out_y` = −9±3.
- Overrun: second `frame_start` 5 cycles after the first → `overrun` pulse, `theta` unchanged, exactly NPTS `out_valid` cycles with indices 0..NPTS−1 in order.
- Reset mid-frame: assert `reset` at edge 8 → `out_valid`=0 forever after; a fresh frame after release yields the normal sequence.
